// File: rtl/rv32im_alu.sv
// Execute-stage ALU for RV32IM: combinational result, registered copy and zero flag.
// Define ALU_MEXT_EN to build the multiply/divide unit; without it codes 01000-01111 return 0.
module rv32im_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [4:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_R,
  output logic             ZERO
);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;
  localparam logic [4:0] OP_SUB    = 5'b10000;
  localparam logic [4:0] OP_SRA    = 5'b10101;
  localparam logic [4:0] OP_FWD    = 5'b11111;

  logic [4:0]       shamt;
  logic [WIDTH-1:0] base_result;

  assign shamt = DATA2[4:0];

  always_comb begin
    base_result = '0;
    case (SELECT)
      OP_ADD:  base_result = DATA1 + DATA2;
      OP_SUB:  base_result = DATA1 - DATA2;
      OP_SLL:  base_result = DATA1 << shamt;
      OP_SLT:  base_result = {{(WIDTH-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
      OP_SLTU: base_result = {{(WIDTH-1){1'b0}}, (DATA1 < DATA2)};
      OP_XOR:  base_result = DATA1 ^ DATA2;
      OP_SRL:  base_result = DATA1 >> shamt;
      OP_SRA:  base_result = $signed(DATA1) >>> shamt;
      OP_OR:   base_result = DATA1 | DATA2;
      OP_AND:  base_result = DATA1 & DATA2;
      OP_FWD:  base_result = DATA2;
      default: base_result = '0;
    endcase
  end

`ifdef ALU_MEXT_EN
  logic [2*WIDTH-1:0]     mul_a;
  logic [2*WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]     product;
  logic signed [WIDTH-1:0] div_a;
  logic signed [WIDTH-1:0] div_b;
  logic [WIDTH-1:0]       quot_s;
  logic [WIDTH-1:0]       rem_s;
  logic [WIDTH-1:0]       quot_u;
  logic [WIDTH-1:0]       rem_u;
  logic                   div_zero;
  logic                   div_ovf;
  logic [WIDTH-1:0]       mext_result;

  // One 64-bit multiplier serves all four ops: the low 64 bits of the product of
  // sign/zero-extended operands are correct for every signedness mix.
  always_comb begin
    mul_a = {{WIDTH{1'b0}}, DATA1};
    mul_b = {{WIDTH{1'b0}}, DATA2};
    if (SELECT == OP_MULH || SELECT == OP_MULHSU) mul_a = {{WIDTH{DATA1[WIDTH-1]}}, DATA1};
    if (SELECT == OP_MULH) mul_b = {{WIDTH{DATA2[WIDTH-1]}}, DATA2};
  end

  assign product  = mul_a * mul_b;
  assign div_a    = $signed(DATA1);
  assign div_b    = $signed(DATA2);
  assign div_zero = (DATA2 == '0);
  assign div_ovf  = (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);

  always_comb begin
    quot_s = '1;
    rem_s  = DATA1;
    quot_u = '1;
    rem_u  = DATA1;
    if (!div_zero) begin
      quot_u = DATA1 / DATA2;
      rem_u  = DATA1 % DATA2;
      if (div_ovf) begin
        quot_s = DATA1;
        rem_s  = '0;
      end else begin
        quot_s = div_a / div_b;
        rem_s  = div_a % div_b;
      end
    end
  end

  always_comb begin
    mext_result = '0;
    case (SELECT)
      OP_MUL:    mext_result = product[WIDTH-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  mext_result = product[2*WIDTH-1:WIDTH];
      OP_DIV:    mext_result = quot_s;
      OP_DIVU:   mext_result = quot_u;
      OP_REM:    mext_result = rem_s;
      OP_REMU:   mext_result = rem_u;
      default:   mext_result = '0;
    endcase
  end

  assign RESULT = (SELECT[4:3] == 2'b01) ? mext_result : base_result;
`else
  assign RESULT = base_result;
`endif

  assign ZERO = (RESULT == '0);

  always_ff @(posedge CLK) begin
    if (RESET) RESULT_R <= '0;
    else       RESULT_R <= RESULT;
  end

endmodule

// File: tb/tb_rv32im_alu.sv
// Directed-vector self-checking bench for rv32im_alu; M-extension expectations follow ALU_MEXT_EN.
module tb_rv32im_alu;

`ifdef ALU_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  SELECT;
  logic [31:0] RESULT;
  logic [31:0] RESULT_R;
  logic        ZERO;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } vec_t;

  rv32im_alu #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2),
    .RESULT(RESULT), .SELECT(SELECT), .RESULT_R(RESULT_R), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    RESET = 1'b1; DATA1 = 32'd0; DATA2 = 32'd0; SELECT = 5'b00000;
    @(posedge CLK); #1;
    vectors++;
    if (RESULT_R !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_value: RESULT_R=%h expected 00000000", RESULT_R);
    end
    RESET = 1'b0;
  endtask

  task automatic test_rv32i();
    vec_t v[19] = '{
      '{5'b00000, 32'd5,          32'd10,         32'd15},
      '{5'b10000, 32'd15,         32'd10,         32'd5},
      '{5'b10000, 32'd0,          32'd1,          32'hFFFFFFFF},
      '{5'b10000, 32'd7,          32'd7,          32'd0},
      '{5'b00000, 32'hFFFFFFFF,   32'd1,          32'd0},
      '{5'b00001, 32'd25,         32'd2,          32'd100},
      '{5'b00101, 32'd32,         32'd2,          32'd8},
      '{5'b10101, 32'hFFFFFFE0,   32'd2,          32'hFFFFFFF8},
      '{5'b00001, 32'd1,          32'h22,         32'd4},
      '{5'b10101, 32'h40000000,   32'd4,          32'h04000000},
      '{5'b00101, 32'h80000000,   32'hFFFFFFFF,   32'd1},
      '{5'b00100, 32'd10,         32'd5,          32'd15},
      '{5'b00110, 32'd12,         32'd5,          32'd13},
      '{5'b00111, 32'd12,         32'd5,          32'd4},
      '{5'b00010, 32'hFFFFFFFF,   32'd1,          32'd1},
      '{5'b00010, 32'd1,          32'hFFFFFFFF,   32'd0},
      '{5'b00011, 32'hFFFFFFFF,   32'd1,          32'd0},
      '{5'b00011, 32'd1,          32'hFFFFFFFF,   32'd1},
      '{5'b11111, 32'hDEADBEEF,   32'h12345000,   32'h12345000}
    };
    foreach (v[i]) begin
      @(negedge CLK);
      DATA1 = v[i].a; DATA2 = v[i].b; SELECT = v[i].sel;
      #1;
      vectors++;
      if (RESULT !== v[i].want) begin
        miscompares++;
        $display("FAIL rv32i[%0d] sel=%b: RESULT=%h expected %h", i, v[i].sel, RESULT, v[i].want);
      end
      vectors++;
      if (ZERO !== (v[i].want == 32'd0)) begin
        miscompares++;
        $display("FAIL rv32i_zero[%0d]: ZERO=%b expected %b", i, ZERO, v[i].want == 32'd0);
      end
    end
  endtask

  task automatic test_mext();
    vec_t v[20] = '{
      '{5'b01000, 32'd4,          32'd5,          32'd20},
      '{5'b01000, 32'hFFFFFFFF,   32'd3,          32'hFFFFFFFD},
      '{5'b01001, 32'd131073,     32'd131073,     32'd4},
      '{5'b01001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0},
      '{5'b01011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE},
      '{5'b01010, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF},
      '{5'b01010, 32'd2,          32'h80000000,   32'd1},
      '{5'b01100, 32'd32,         32'd2,          32'd16},
      '{5'b01110, 32'd31,         32'd2,          32'd1},
      '{5'b01100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD},
      '{5'b01110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF},
      '{5'b01100, 32'd1234,       32'd0,          32'hFFFFFFFF},
      '{5'b01101, 32'd7,          32'd0,          32'hFFFFFFFF},
      '{5'b01110, 32'd5,          32'd0,          32'd5},
      '{5'b01111, 32'd9,          32'd0,          32'd9},
      '{5'b01100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000},
      '{5'b01110, 32'h80000000,   32'hFFFFFFFF,   32'd0},
      '{5'b01101, 32'd100,        32'd7,          32'd14},
      '{5'b01111, 32'd100,        32'd7,          32'd2},
      '{5'b01101, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC}
    };
    logic [31:0] want;
    foreach (v[i]) begin
      @(negedge CLK);
      DATA1 = v[i].a; DATA2 = v[i].b; SELECT = v[i].sel;
      want = MEXT ? v[i].want : 32'd0;
      #1;
      vectors++;
      if (RESULT !== want) begin
        miscompares++;
        $display("FAIL mext[%0d] sel=%b: RESULT=%h expected %h", i, v[i].sel, RESULT, want);
      end
      vectors++;
      if (ZERO !== (want == 32'd0)) begin
        miscompares++;
        $display("FAIL mext_zero[%0d]: ZERO=%b expected %b", i, ZERO, want == 32'd0);
      end
    end
  endtask

  task automatic test_unused_codes();
    logic [4:0] codes[6] = '{5'b10001, 5'b10010, 5'b10100, 5'b10110, 5'b11000, 5'b11110};
    foreach (codes[i]) begin
      @(negedge CLK);
      DATA1 = 32'hA5A5A5A5; DATA2 = 32'h0F0F0F0F; SELECT = codes[i];
      #1;
      vectors++;
      if (RESULT !== 32'd0 || ZERO !== 1'b1) begin
        miscompares++;
        $display("FAIL unused[%b]: RESULT=%h ZERO=%b expected 00000000 1", codes[i], RESULT, ZERO);
      end
    end
  endtask

  task automatic test_result_r();
    @(negedge CLK);
    RESET = 1'b0; DATA1 = 32'd0; DATA2 = 32'd1; SELECT = 5'b10000;
    @(posedge CLK); #1;
    vectors++;
    if (RESULT_R !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL result_r_load: RESULT_R=%h expected ffffffff", RESULT_R);
    end
    @(negedge CLK);
    RESET = 1'b1; DATA1 = 32'd5; DATA2 = 32'd10; SELECT = 5'b00000;
    @(posedge CLK); #1;
    vectors++;
    if (RESULT_R !== 32'd0) begin
      miscompares++;
      $display("FAIL result_r_reset: RESULT_R=%h expected 00000000", RESULT_R);
    end
    vectors++;
    if (RESULT !== 32'd15) begin
      miscompares++;
      $display("FAIL result_during_reset: RESULT=%h expected 0000000f", RESULT);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (RESULT_R !== 32'd15) begin
      miscompares++;
      $display("FAIL result_r_after_reset: RESULT_R=%h expected 0000000f", RESULT_R);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[5] = '{
      '{5'b00000, 32'd1,        32'd2,        32'd3},
      '{5'b00100, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0},
      '{5'b10000, 32'd9,        32'd9,        32'd0},
      '{5'b11111, 32'd0,        32'hCAFEF00D, 32'hCAFEF00D},
      '{5'b00001, 32'h80000001, 32'd1,        32'h00000002}
    };
    foreach (v[i]) begin
      @(negedge CLK);
      DATA1 = v[i].a; DATA2 = v[i].b; SELECT = v[i].sel;
      @(posedge CLK); #1;
      vectors++;
      if (RESULT_R !== v[i].want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: RESULT_R=%h expected %h", i, RESULT_R, v[i].want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rv32i();
    test_mext();
    test_unused_codes();
    test_result_r();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
